// File: rtl/simon_pkg.sv
// simon_pkg: shared definitions for the Simon encryption core.
//   - default geometry (Simon32/64, 32 rounds)
//   - Z0 sequence constant (bit j is the j-th element of the sequence)
//   - FSM state encoding
//   - simon_f(): round function on a word of width n (n <= W_MAX)
package simon_pkg;

  localparam int N_DEF = 16;
  localparam int M_DEF = 4;
  localparam int T_DEF = 32;

  localparam int W_MAX = 64;
  localparam int Z_LEN = 62;

  // Written LSB-first relative to the published sequence: Z0[0] is the first element.
  localparam logic [Z_LEN-1:0] Z0 =
    62'b01100111000011010100100010111110110011100001101010010001011111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Rotate left by s within the low n bits; bits at and above n are returned as zero.
  function automatic logic [W_MAX-1:0] rol_n(input logic [W_MAX-1:0] x,
                                             input int s,
                                             input int n);
    logic [W_MAX-1:0] mask;
    int               sh;
    mask = (n >= W_MAX) ? '1 : ((W_MAX'(1) << n) - W_MAX'(1));
    sh   = s % n;
    if (sh == 0) return x & mask;
    return ((x << sh) | ((x & mask) >> (n - sh))) & mask;
  endfunction

  // f(x) = (rol1(x) & rol8(x)) ^ rol2(x), rotations modulo n
  function automatic logic [W_MAX-1:0] simon_f(input logic [W_MAX-1:0] x,
                                               input int n);
    return (rol_n(x, 1, n) & rol_n(x, 8, n)) ^ rol_n(x, 2, n);
  endfunction

endpackage

// File: rtl/simon_round.sv
// simon_round: one combinational forward Simon round.
//   {hi, lo} -> {lo ^ f(hi) ^ k, hi}
// Ports:
//   hi_i, lo_i  upper / lower state word in
//   k_i         round key
//   hi_o, lo_o  upper / lower state word out
module simon_round
  import simon_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] hi_i,
  input  logic [N-1:0] lo_i,
  input  logic [N-1:0] k_i,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o
);

  logic [N-1:0] f_w;

  assign f_w  = N'(simon_f(W_MAX'(hi_i), N));
  assign hi_o = lo_i ^ f_w ^ k_i;
  assign lo_o = hi_i;

endmodule

// File: rtl/simon_encrypt_iter.sv
// simon_encrypt_iter: iterative Simon encryption core, one round per clock,
// key schedule expanded on the fly (M = 4 only).
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   plaintext + master key handshake
//   pt [2N]             plaintext {hi, lo}
//   key [M*N]           master key, k0 in the low word
//   out_valid/out_ready ciphertext handshake
//   ct [2N]             ciphertext {hi, lo}, held stable while out_valid
//   last_key [M*N]      only with SIMON_LAST_KEY_EN: schedule words
//                       k(T-4)..k(T-1), k(T-4) in the low word, for the
//                       decryptor to run the schedule backward
module simon_encrypt_iter
  import simon_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int T = T_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] pt,
  input  logic [M*N-1:0] key,
  output logic           out_valid,
  input  logic           out_ready,
`ifdef SIMON_LAST_KEY_EN
  output logic [M*N-1:0] last_key,
`endif
  output logic [2*N-1:0] ct
);

  localparam int RW = $clog2(T);

  state_e          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [2*N-1:0]  ct_q;
  logic [2*N-1:0]  x_q;
  logic [N-1:0]    kr_q [4];
  logic [RW-1:0]   round_q;
  logic [5:0]      j_q;

  logic [N-1:0]    hi_d;
  logic [N-1:0]    lo_d;
  logic [2*N-1:0]  x_d;
  logic [N-1:0]    tmp_a;
  logic [N-1:0]    tmp_b;
  logic [N-1:0]    kr3_d;
  logic            last_round;

  simon_round #(.N(N)) u_round (
    .hi_i (x_q[2*N-1:N]),
    .lo_i (x_q[N-1:0]),
    .k_i  (kr_q[0]),
    .hi_o (hi_d),
    .lo_o (lo_d)
  );

  assign x_d = {hi_d, lo_d};

  // Next schedule word: ~k(i) ^ tmp ^ z0[j] ^ 3
  assign tmp_a = {kr_q[3][2:0], kr_q[3][N-1:3]} ^ kr_q[1];
  assign tmp_b = tmp_a ^ {tmp_a[0], tmp_a[N-1:1]};
  assign kr3_d = ~kr_q[0] ^ tmp_b ^ N'(Z0[j_q]) ^ N'(3);

  assign last_round = (round_q == RW'(T - 1));

`ifdef SIMON_LAST_KEY_EN
  // Words k(T-4)..k(T-1) are in the shift register at round T-4; they are
  // staged there and published together with ct.
  logic [M*N-1:0] lk_stage_q;
  logic [M*N-1:0] last_key_q;
  assign last_key = last_key_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ct_q        <= '0;
      x_q         <= '0;
      kr_q[0]     <= '0;
      kr_q[1]     <= '0;
      kr_q[2]     <= '0;
      kr_q[3]     <= '0;
      round_q     <= '0;
      j_q         <= '0;
`ifdef SIMON_LAST_KEY_EN
      lk_stage_q  <= '0;
      last_key_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            x_q        <= pt;
            kr_q[0]    <= key[0*N +: N];
            kr_q[1]    <= key[1*N +: N];
            kr_q[2]    <= key[2*N +: N];
            kr_q[3]    <= key[3*N +: N];
            round_q    <= '0;
            j_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          x_q     <= x_d;
          kr_q[0] <= kr_q[1];
          kr_q[1] <= kr_q[2];
          kr_q[2] <= kr_q[3];
          kr_q[3] <= kr3_d;
          j_q     <= (j_q == 6'(Z_LEN - 1)) ? 6'd0 : j_q + 6'd1;
`ifdef SIMON_LAST_KEY_EN
          if (round_q == RW'(T - 4)) begin
            lk_stage_q <= {kr_q[3], kr_q[2], kr_q[1], kr_q[0]};
          end
`endif
          if (last_round) begin
            ct_q        <= x_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef SIMON_LAST_KEY_EN
            last_key_q  <= lk_stage_q;
`endif
          end else begin
            round_q <= round_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ct        = ct_q;

endmodule

// File: tb/tb_simon_encrypt_iter.sv
module tb_simon_encrypt_iter;

  localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] KAT_PT  = 32'h6565_6877;
  localparam logic [31:0] KAT_CT  = 32'hc69b_e9bb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pt = '0;
  logic [63:0] key = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ct;
`ifdef SIMON_LAST_KEY_EN
  logic [63:0] last_key;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ks [32];
  // Published sequence order: leftmost character is element 0.
  logic [61:0] zs = 62'b11111010001001010110000111001101111101000100101011000011100110;

  simon_encrypt_iter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt        (pt),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SIMON_LAST_KEY_EN
    .last_key  (last_key),
`endif
    .ct        (ct)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] f16(input logic [15:0] x);
    return ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
  endfunction

  task automatic gen_keys(input logic [63:0] k);
    logic [15:0] tmp;
    for (int i = 0; i < 4; i++) ks[i] = k[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      tmp   = {ks[i-1][2:0], ks[i-1][15:3]} ^ ks[i-3];
      tmp   = tmp ^ {tmp[0], tmp[15:1]};
      ks[i] = ~ks[i-4] ^ tmp ^ {15'd0, zs[61 - ((i - 4) % 62)]} ^ 16'd3;
    end
  endtask

  function automatic logic [31:0] model_enc(input logic [31:0] p);
    logic [15:0] hi, lo, t;
    hi = p[31:16];
    lo = p[15:0];
    for (int i = 0; i < 32; i++) begin
      t  = hi;
      hi = lo ^ f16(hi) ^ ks[i];
      lo = t;
    end
    return {hi, lo};
  endfunction

  function automatic logic [31:0] model_dec(input logic [31:0] c);
    logic [15:0] hi, lo, t;
    hi = c[31:16];
    lo = c[15:0];
    for (int i = 31; i >= 0; i--) begin
      t  = lo;
      lo = hi ^ f16(lo) ^ ks[i];
      hi = t;
    end
    return {hi, lo};
  endfunction

  task automatic send(input logic [31:0] p, input logic [63:0] k, output bit ok);
    int cnt;
    pt = p;
    key = k;
    in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 200) begin
      tick();
      cnt++;
    end
    ok = in_ready;
    if (ok) tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++;
    if (ct !== 32'h0) begin n_fail++; $display("FAIL reset_ct got=%h want=00000000", ct); end
  endtask

  task automatic test_kat();
    bit ok;
    int cyc;
    send(KAT_PT, KAT_KEY, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL kat_accept got=%b want=1", ok); end
    wait_out(cyc);
    n_checks++;
    if (cyc !== 32) begin n_fail++; $display("FAIL kat_latency got=%0d want=32", cyc); end
    n_checks++;
    if (ct !== KAT_CT) begin n_fail++; $display("FAIL kat_ct got=%h want=%h", ct, KAT_CT); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL kat_busy_in_ready got=%b want=0", in_ready); end
`ifdef SIMON_LAST_KEY_EN
    gen_keys(KAT_KEY);
    n_checks++;
    if (last_key !== {ks[31], ks[30], ks[29], ks[28]}) begin
      n_fail++;
      $display("FAIL kat_last_key got=%h want=%h", last_key, {ks[31], ks[30], ks[29], ks[28]});
    end
`endif
    take_out();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL kat_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    send(KAT_PT, KAT_KEY, ok);
    wait_out(cyc);
    n_checks++;
    if (cyc !== 32) begin n_fail++; $display("FAIL bp_latency got=%0d want=32", cyc); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        pt = 32'hdead_beef;
        key = 64'h0;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      n_checks++;
      if (ct !== KAT_CT) begin n_fail++; $display("FAIL bp_ct_stable cycle=%0d got=%h want=%h", i, ct, KAT_CT); end
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cycle=%0d got=%b want=1", i, out_valid); end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle=%0d got=%b want=0", i, in_ready); end
    end
    in_valid = 1'b0;
    take_out();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_idle_after cycle=%0d got out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          acc_cyc [2];
    int          n_acc, n_out, cyc;
    logic [31:0] got [2];
    logic [31:0] exp1;
    bit          pre;
    gen_keys(64'h0);
    exp1 = model_enc(32'h0);
    n_acc = 0;
    n_out = 0;
    cyc = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    got[0] = '0;
    got[1] = '0;
    pt = KAT_PT;
    key = KAT_KEY;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (n_out < 2 && cyc < 300) begin
      if (out_valid && n_out < 2) begin
        got[n_out] = ct;
        n_out++;
      end
      pre = in_ready;
      tick();
      cyc++;
      if (in_valid && pre && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          pt = 32'h0;
          key = 64'h0;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (n_out !== 2) begin n_fail++; $display("FAIL b2b_outputs got=%0d want=2", n_out); end
    n_checks++;
    if (got[0] !== KAT_CT) begin n_fail++; $display("FAIL b2b_ct0 got=%h want=%h", got[0], KAT_CT); end
    n_checks++;
    if (got[1] !== exp1) begin n_fail++; $display("FAIL b2b_ct1 got=%h want=%h", got[1], exp1); end
    n_checks++;
    if (n_acc !== 2 || (acc_cyc[1] - acc_cyc[0]) !== 34) begin
      n_fail++;
      $display("FAIL b2b_gap got accepts=%0d gap=%0d want 2/34", n_acc, acc_cyc[1] - acc_cyc[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int cyc;
    send(KAT_PT, KAT_KEY, ok);
    repeat (15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); end
    n_checks++;
    if (ct !== 32'h0) begin n_fail++; $display("FAIL rst_mid_ct got=%h want=00000000", ct); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_output got=%b want=0", seen); end
    send(KAT_PT, KAT_KEY, ok);
    wait_out(cyc);
    n_checks++;
    if (ct !== KAT_CT || cyc !== 32) begin
      n_fail++;
      $display("FAIL rst_mid_rerun got ct=%h lat=%0d want %h/32", ct, cyc, KAT_CT);
    end
    take_out();
  endtask

  task automatic test_roundtrip();
    bit          ok;
    int          cyc;
    logic [63:0] k;
    logic [31:0] p, c, d;
    for (int it = 0; it < 1000; it++) begin
      k = {$urandom(), $urandom()};
      p = $urandom();
      send(p, k, ok);
      wait_out(cyc);
      c = ct;
      take_out();
      gen_keys(k);
      d = model_dec(c);
      n_checks++;
      if (d !== p || cyc !== 32) begin
        n_fail++;
        $display("FAIL roundtrip it=%0d key=%h pt=%h ct=%h got_dec=%h lat=%0d want pt/32", it, k, p, c, d, cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_kat();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_roundtrip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
